// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned REG_ZERO  = 0;

    // The helper below works on fixed-width padded vectors so one function serves every
    // parameterisation; NWR and AW must not exceed these bounds.
    localparam int unsigned MAX_WR = 16;
    localparam int unsigned MAX_AW = 16;

    // Address width for n registers, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the highest write port enabled for addr, or -1 when no port matches.
    function automatic int win_port(input logic [MAX_WR-1:0]        en,
                                    input logic [MAX_WR*MAX_AW-1:0] addrs,
                                    input logic [MAX_AW-1:0]        addr);
        int w;
        w = -1;
        for (int j = 0; j < int'(MAX_WR); j++) begin
            if (en[j] && addrs[j*MAX_AW +: MAX_AW] == addr) w = j;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port forwarding mux: picks same-cycle write data over the stored value.
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned AW       = 5,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [XLEN-1:0]     stored,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [XLEN-1:0]     fwd_data,
    output logic                hit
);

    logic [MAX_WR-1:0]        en_pad;
    logic [MAX_WR*MAX_AW-1:0] addr_pad;
    int                       win;

    // Find the winning write port for this read address and select its data.
    always_comb begin
        en_pad   = '0;
        addr_pad = '0;
        for (int j = 0; j < int'(NWR); j++) begin
            en_pad[j]                     = wr_en[j];
            addr_pad[j*MAX_AW +: MAX_AW]  = MAX_AW'(wr_addr[j*AW +: AW]);
        end
        win      = win_port(en_pad, addr_pad, MAX_AW'(rd_addr));
        hit      = (win >= 0) && !((ZERO_REG != 0) && (rd_addr == AW'(REG_ZERO)));
        fwd_data = stored;
        for (int j = 0; j < int'(NWR); j++) begin
            if (hit && win == j) fwd_data = wr_data[j*XLEN +: XLEN];
        end
    end

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-port integer register file with optional write bypass and a busy scoreboard.
module reg_file_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                sb_flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_d;
    logic [NWR-1:0]   we;

    // Writes are gated by reset so the bypass path also sees nothing while rstn is low.
    assign we = rstn ? wr_en : '0;

    // Register array update; later ports overwrite earlier ones on address conflicts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
        end else begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (we[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == AW'(REG_ZERO)))) begin
                    regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard next state: flush > set > writeback clear > hold; count the result.
    always_comb begin
        busy_d = busy_q;
        if (sb_flush) begin
            busy_d = '0;
        end else begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (we[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
            if (sb_set && !((ZERO_REG != 0) && (sb_addr == AW'(REG_ZERO)))) begin
                busy_d[sb_addr] = 1'b1;
            end
        end
        cnt_d = '0;
        for (int r = 0; r < int'(NREGS); r++) cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end

    // Scoreboard and its population count share one edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] stored;
        logic [XLEN-1:0] data;
        logic            hit;

        assign raddr  = rd_addr[i*AW +: AW];
        assign stored = ((ZERO_REG != 0) && (raddr == AW'(REG_ZERO))) ? '0 : regs_q[raddr];

        if (BYPASS != 0) begin : g_byp
            regfile_fwd_mux #(
                .XLEN     (XLEN),
                .AW       (AW),
                .NWR      (NWR),
                .ZERO_REG (ZERO_REG)
            ) u_fwd (
                .stored   (stored),
                .wr_en    (we),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .rd_addr  (raddr),
                .fwd_data (data),
                .hit      (hit)
            );
        end else begin : g_nobyp
            assign data = stored;
            assign hit  = 1'b0;
        end

        // A bypassed write resolves the hazard in the same cycle.
        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy_q[raddr] & ~hit;
    end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Self-checking bench: table of per-cycle vectors with a scoreboard queue, plus reset sequence.
module tb_reg_file_mp_sb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;
    localparam logic [63:0] V3   = 64'h1234_5678_9ABC_DEF0;

    logic             clk = 1'b0;
    logic             rstn;
    logic [2*AW-1:0]  rd_addr;
    logic [2*XLEN-1:0] rd_data, rd_data_nb;
    logic [1:0]       rd_busy, rd_busy_nb;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_flush;
    logic [AW:0]      busy_cnt, busy_cnt_nb;

    always #5 clk = ~clk;

    reg_file_mp_sb #(.BYPASS(1)) dut (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
        .sb_addr(sb_addr), .sb_flush(sb_flush), .busy_cnt(busy_cnt)
    );

    reg_file_mp_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush), .busy_cnt(busy_cnt_nb)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic        set;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [63:0] enb;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    typedef struct {
        logic [63:0] e0;
        logic [63:0] e1;
        logic [63:0] enb;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [63:0] wd0,
                                logic [4:0] wa1, logic [63:0] wd1, logic set, logic [4:0] sa,
                                logic fl, logic [4:0] ra0, logic [4:0] ra1, logic [63:0] e0,
                                logic [63:0] e1, logic [63:0] enb, logic [1:0] eb,
                                logic [5:0] ec);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.set = set; v.sa = sa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.enb = enb; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
    endtask

    initial begin
        exp_t e;
        rd_addr = '0;
        idle_inputs();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        check("reset rd0", rd_data[63:0], 64'h0);
        check("reset rd1", rd_data[127:64], 64'h0);
        check("reset busy", 64'(rd_busy), 64'h0);
        check("reset cnt", 64'(busy_cnt), 64'h0);

        //          we     wa0 wd0      wa1 wd1    set sa  fl ra0 ra1 e0       e1  enb      eb     ec
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 3,  7,  0,       0,  0,       2'b00, 0));
        vecs.push_back(mk(2'b01, 3, V3,      0, 0,     0, 0,  0, 3,  3,  V3,      V3, 0,       2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 3,  7,  V3,      0,  V3,      2'b00, 0));
        vecs.push_back(mk(2'b11, 7, 64'h11,  7, 64'h22, 0, 0, 0, 7,  3,  64'h22,  V3, 0,       2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 7,  0,  64'h22,  0,  64'h22,  2'b00, 0));
        vecs.push_back(mk(2'b01, 0, 64'hFF,  0, 0,     1, 0,  0, 0,  0,  0,       0,  0,       2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 0,  9,  0,       0,  0,       2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     1, 9,  0, 9,  0,  0,       0,  0,       2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 9,  0,  0,       0,  0,       2'b01, 1));
        vecs.push_back(mk(2'b01, 9, 64'h5,   0, 0,     1, 9,  0, 9,  0,  64'h5,   0,  0,       2'b00, 1));
        vecs.push_back(mk(2'b01, 9, 64'h6,   0, 0,     0, 0,  0, 9,  9,  64'h6,   64'h6, 64'h5, 2'b00, 1));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 9,  3,  64'h6,   V3, 64'h6,   2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     1, 1,  0, 1,  2,  0,       0,  0,       2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     1, 2,  0, 1,  2,  0,       0,  0,       2'b01, 1));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     1, 3,  0, 1,  2,  0,       0,  0,       2'b11, 2));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     1, 4,  1, 3,  4,  V3,      0,  V3,      2'b01, 3));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 3,  4,  V3,      0,  V3,      2'b00, 0));
        vecs.push_back(mk(2'b00, 0, 0,       0, 0,     0, 0,  0, 1,  2,  0,       0,  0,       2'b00, 0));

        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wr_en   = vecs[i].we;
            wr_addr = {vecs[i].wa1, vecs[i].wa0};
            wr_data = {vecs[i].wd1, vecs[i].wd0};
            sb_set  = vecs[i].set;
            sb_addr = vecs[i].sa;
            sb_flush = vecs[i].fl;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            e.e0 = vecs[i].e0; e.e1 = vecs[i].e1; e.enb = vecs[i].enb;
            e.eb = vecs[i].eb; e.ec = vecs[i].ec;
            sb_q.push_back(e);
            #2;
            e = sb_q.pop_front();
            check($sformatf("v%0d rd0", i), rd_data[63:0], e.e0);
            check($sformatf("v%0d rd1", i), rd_data[127:64], e.e1);
            check($sformatf("v%0d nobyp rd0", i), rd_data_nb[63:0], e.enb);
            check($sformatf("v%0d busy", i), 64'(rd_busy), 64'(e.eb));
            check($sformatf("v%0d cnt", i), 64'(busy_cnt), 64'(e.ec));
        end

        // Reset mid-operation: x5 written and marked busy, then an in-flight write is discarded.
        @(negedge clk);
        idle_inputs();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'h0, 64'hDEAD};
        sb_set = 1'b1; sb_addr = 5'd5;
        rd_addr = {5'd5, 5'd5};
        @(negedge clk);
        idle_inputs();
        #1;
        check("x5 stored", rd_data[63:0], 64'hDEAD);
        check("x5 busy", 64'(rd_busy), 64'h3);
        check("x5 cnt", 64'(busy_cnt), 64'h1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'h0, 64'hBEEF};
        #1 rstn = 1'b0;
        #1;
        check("rst rd x5", rd_data[63:0], 64'h0);
        check("rst busy", 64'(rd_busy), 64'h0);
        check("rst cnt", 64'(busy_cnt), 64'h0);
        @(posedge clk);
        #1;
        check("rst hold rd x5", rd_data[63:0], 64'h0);
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post rst rd x5", rd_data[63:0], 64'h0);
        check("post rst nobyp x5", rd_data_nb[63:0], 64'h0);
        check("post rst cnt", 64'(busy_cnt), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
